// File: rtl/maint_monitor_fsm.sv
// -----------------------------------------------------------------------------
// maint_monitor_fsm
//
// Maintenance-interval monitor. It counts qualified cycles (tick) since the
// last maintenance event and counts the maintenance events themselves. In RUN
// it raises warn once the interval reaches WARN_LIMIT. When the interval
// reaches FAIL_LIMIT it enters a sticky ALARM. ALARM is left only by a
// maintenance event that is acknowledged with clr_alarm on the same edge.
//
// Ports
//   clk        in   1      single clock, all state on posedge
//   rst        in   1      synchronous, active-high reset
//   tick       in   1      interval-count enable
//   m          in   1      maintenance event
//   clr_alarm  in   1      alarm acknowledge, effective only together with m
//   msj_f      out  MSG_W  maintenance count, all-ones while in ALARM
//   maint_cnt  out  MSG_W  raw maintenance count
//   state_o    out  2      state: IDLE=00 SERVICE=01 RUN=10 ALARM=11
//   warn       out  1      interval >= WARN_LIMIT while in RUN
//   alarm      out  1      state is ALARM
// -----------------------------------------------------------------------------
module maint_monitor_fsm #(
    parameter int MSG_W      = 8,
    parameter int CNT_W      = 16,
    parameter int WARN_LIMIT = 200,
    parameter int FAIL_LIMIT = 250
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             m,
    input  logic             clr_alarm,
    output logic [MSG_W-1:0] msj_f,
    output logic [MSG_W-1:0] maint_cnt,
    output logic [1:0]       state_o,
    output logic             warn,
    output logic             alarm
);

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_SERVICE = 2'b01;
    localparam logic [1:0] S_RUN     = 2'b10;
    localparam logic [1:0] S_ALARM   = 2'b11;

    localparam logic [CNT_W-1:0] WARN_C      = CNT_W'(WARN_LIMIT);
    localparam logic [CNT_W-1:0] FAIL_C      = CNT_W'(FAIL_LIMIT);
    localparam logic [CNT_W-1:0] FAIL_M1_C   = CNT_W'(FAIL_LIMIT - 1);
    // All-ones is reserved for the alarm code on msj_f, so the count stops
    // one below it.
    localparam logic [MSG_W-1:0] CNT_MAX_C   = {{(MSG_W-1){1'b1}}, 1'b0};

    generate
        if (!(WARN_LIMIT > 0 && WARN_LIMIT < FAIL_LIMIT &&
              64'(FAIL_LIMIT) <= ((64'(1) << CNT_W) - 64'(1)))) begin : g_bad_limits
            $error("maint_monitor_fsm: need 0 < WARN_LIMIT < FAIL_LIMIT <= 2^CNT_W-1");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cyc_q,   cyc_d;
    logic [MSG_W-1:0] cnt_q,   cnt_d;
    logic             enter_svc;

    function automatic logic [MSG_W-1:0] sat_inc(input logic [MSG_W-1:0] v);
        return (v >= CNT_MAX_C) ? CNT_MAX_C : v + MSG_W'(1);
    endfunction

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        cnt_d     = cnt_q;
        enter_svc = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (m) enter_svc = 1'b1;
                else   state_d   = S_RUN;
            end
            S_SERVICE: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                // Maintenance wins over reaching the limit on the same edge.
                if (m) begin
                    enter_svc = 1'b1;
                end else if (tick && cyc_q == FAIL_M1_C) begin
                    cyc_d   = FAIL_C;
                    state_d = S_ALARM;
                end else if (tick) begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            default: begin  // S_ALARM: sticky until acknowledged maintenance
                if (m && clr_alarm) enter_svc = 1'b1;
            end
        endcase

        if (enter_svc) begin
            state_d = S_SERVICE;
            cyc_d   = '0;
            cnt_d   = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o   = state_q;
    assign maint_cnt = cnt_q;
    assign alarm     = (state_q == S_ALARM);
    assign msj_f     = alarm ? {MSG_W{1'b1}} : cnt_q;
    assign warn      = (state_q == S_RUN) && (cyc_q >= WARN_C);

endmodule

// File: tb/tb_maint_monitor_fsm.sv
// -----------------------------------------------------------------------------
// tb_maint_monitor_fsm
//
// Bench for maint_monitor_fsm with MSG_W=8, CNT_W=4, WARN_LIMIT=3,
// FAIL_LIMIT=5. A driver applies inputs at the falling edge and pushes the
// expected post-edge outputs from a behavioural model; a monitor pops and
// compares one entry after every rising edge.
// -----------------------------------------------------------------------------
module tb_maint_monitor_fsm;

    localparam int MSG_W = 8;
    localparam int CNT_W = 4;
    localparam int WARN  = 3;
    localparam int FAIL  = 5;
    localparam int CMAX  = 254;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick = 1'b0;
    logic             m = 1'b0;
    logic             clr_alarm = 1'b0;
    logic [MSG_W-1:0] msj_f;
    logic [MSG_W-1:0] maint_cnt;
    logic [1:0]       state_o;
    logic             warn;
    logic             alarm;

    int tests  = 0;
    int fails  = 0;

    maint_monitor_fsm #(
        .MSG_W(MSG_W), .CNT_W(CNT_W), .WARN_LIMIT(WARN), .FAIL_LIMIT(FAIL)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .m(m), .clr_alarm(clr_alarm),
        .msj_f(msj_f), .maint_cnt(maint_cnt), .state_o(state_o),
        .warn(warn), .alarm(alarm)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       st;
        logic [MSG_W-1:0] msj;
        logic [MSG_W-1:0] cnt;
        logic             w;
        logic             a;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model: named modes, plain integer counters.
    typedef enum int {MD_IDLE, MD_SERVICE, MD_RUN, MD_ALARM} mode_t;
    mode_t mode  = MD_IDLE;
    int    mcyc  = 0;
    int    mcnt  = 0;

    function automatic logic [1:0] code_of(input mode_t md);
        case (md)
            MD_IDLE:    return 2'd0;
            MD_SERVICE: return 2'd1;
            MD_RUN:     return 2'd2;
            default:    return 2'd3;
        endcase
    endfunction

    task automatic do_service();
        mode = MD_SERVICE;
        mcyc = 0;
        if (mcnt < CMAX) mcnt = mcnt + 1;
    endtask

    task automatic model_edge(input logic r, input logic t, input logic mm, input logic c);
        if (r) begin
            mode = MD_IDLE; mcyc = 0; mcnt = 0;
        end else begin
            case (mode)
                MD_IDLE:    if (mm) do_service(); else mode = MD_RUN;
                MD_SERVICE: mode = MD_RUN;
                MD_RUN: begin
                    if (mm) do_service();
                    else if (t) begin
                        mcyc = mcyc + 1;
                        if (mcyc >= FAIL) mode = MD_ALARM;
                    end
                end
                MD_ALARM:   if (mm && c) do_service();
            endcase
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.st  = code_of(mode);
        e.a   = (mode == MD_ALARM);
        e.cnt = MSG_W'(mcnt);
        e.msj = e.a ? 8'hFF : MSG_W'(mcnt);
        e.w   = (mode == MD_RUN) && (mcyc >= WARN);
        return e;
    endfunction

    task automatic step(input logic r, input logic t, input logic mm, input logic c);
        @(negedge clk);
        rst = r; tick = t; m = mm; clr_alarm = c;
        model_edge(r, t, mm, c);
        exp_q.push_back(model_out());
        @(posedge clk);
    endtask

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: one scoreboard entry per rising edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (state_o !== e.st || msj_f !== e.msj || maint_cnt !== e.cnt ||
                warn !== e.w || alarm !== e.a) begin
                fails++;
                $display("FAIL scoreboard t=%0t: got st=%0d msj=%0h cnt=%0h w=%0b a=%0b, expected st=%0d msj=%0h cnt=%0h w=%0b a=%0b",
                         $time, state_o, msj_f, maint_cnt, warn, alarm,
                         e.st, e.msj, e.cnt, e.w, e.a);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. reset then idle -> run, counting
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        #2;
        chk("reset_state", state_o, 0);
        chk("reset_msj", msj_f, 0);
        chk("reset_alarm", alarm, 0);
        step(0, 1, 0, 0);
        #2 chk("idle_to_run", state_o, 2);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        #2 chk("warn_at_cyc2", warn, 0);
        step(0, 1, 0, 0);
        #2 chk("warn_at_cyc3", warn, 1);
        chk("msj_run", msj_f, 0);

        // 2. alarm
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        #2;
        chk("alarm_state", state_o, 3);
        chk("alarm_msj", msj_f, 8'hFF);
        chk("alarm_warn", warn, 0);
        step(0, 1, 1, 0);
        #2 chk("alarm_m_only", state_o, 3);

        // 3. recovery
        step(0, 0, 0, 1);
        #2 chk("alarm_clr_only", state_o, 3);
        step(0, 0, 1, 1);
        #2;
        chk("recover_state", state_o, 1);
        chk("recover_msj", msj_f, 1);
        step(0, 1, 0, 0);
        #2;
        chk("recover_run", state_o, 2);
        chk("recover_warn", warn, 0);

        // 4. race at the limit: maintenance wins
        repeat (4) step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        #2;
        chk("race_state", state_o, 1);
        chk("race_cnt", maint_cnt, 2);
        step(0, 0, 0, 0);

        // 5. saturation
        while (mcnt < CMAX) begin
            step(0, 0, 1, 0);
            step(0, 0, 0, 0);
        end
        #2 chk("sat_reach", maint_cnt, 8'hFE);
        step(0, 0, 1, 0);
        #2;
        chk("sat_hold", maint_cnt, 8'hFE);
        chk("sat_msj", msj_f, 8'hFE);
        chk("sat_alarm", alarm, 0);
        step(0, 0, 0, 0);

        // 6. synchronous reset from ALARM
        repeat (5) step(0, 1, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_between_edges_alarm", alarm, 1);
        chk("rst_between_edges_state", state_o, 3);
        step(1, 0, 0, 0);
        #2;
        chk("rst_alarm_state", state_o, 0);
        chk("rst_alarm_msj", msj_f, 0);
        chk("rst_alarm_alarm", alarm, 0);

        // Randomized phase.
        for (int i = 0; i < 1500; i++) begin
            logic r, t, mm, c;
            r  = ($urandom_range(99) < 2);
            t  = ($urandom_range(99) < 70);
            mm = ($urandom_range(99) < 15);
            c  = ($urandom_range(99) < 40);
            step(r, t, mm, c);
        end
        step(0, 0, 0, 0);

        // Let the monitor consume the last entry, bounded.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #5;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
